// File: rtl/morty_imm_gen_pipe.sv
// Registered immediate generator (I/S/B/SHAMT/J/U/ZIMM) with 2-entry skid buffer and tag sideband.
// Optional MORTY_IMM_ERR_EN: flags reserved select 3'b111 on err_o, carried with the entry.
`timescale 1ns/1ps
module morty_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instruction,
  input  logic [2:0]       imm_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [XLEN-1:0] imm_dec;
  logic            err_dec;
  logic            unused_opcode;

  assign unused_opcode = ^instruction[6:0];

  always_comb begin
    imm_dec = '0;
    err_dec = 1'b0;
    case (imm_sel_i)
      3'b000:  imm_dec = XLEN'($signed(instruction[31:20]));
      3'b001:  imm_dec = XLEN'($signed({instruction[31:25], instruction[11:7]}));
      3'b010:  imm_dec = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                         instruction[11:8], 1'b0}));
      3'b011:  imm_dec = XLEN'(instruction[20 +: SHW]);
      3'b100:  imm_dec = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                         instruction[30:21], 1'b0}));
      3'b101:  imm_dec = XLEN'($signed({instruction[31:12], 12'b0}));
      3'b110:  imm_dec = XLEN'(instruction[19:15]);
      default: begin
        imm_dec = '0;
        err_dec = 1'b1;
      end
    endcase
  end

  logic             out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skd_imm_q, skd_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skd_tag_q, skd_tag_d;
`ifdef MORTY_IMM_ERR_EN
  logic             out_err_q, out_err_d, skd_err_q, skd_err_d;
`else
  logic             unused_err;
  assign unused_err = err_dec;
`endif
  logic             accept, drain;

  assign ready_o = !skd_vld_q && !rst_i;
  assign accept  = valid_i && ready_o;
  assign drain   = !out_vld_q || ready_i;

  always_comb begin
    out_vld_d = out_vld_q;
    out_imm_d = out_imm_q;
    out_tag_d = out_tag_q;
    skd_vld_d = skd_vld_q;
    skd_imm_d = skd_imm_q;
    skd_tag_d = skd_tag_q;
`ifdef MORTY_IMM_ERR_EN
    out_err_d = out_err_q;
    skd_err_d = skd_err_q;
`endif
    // Data regs only load with a valid entry so outputs hold while idle.
    if (flush_i) begin
      out_vld_d = 1'b0;
      skd_vld_d = 1'b0;
    end else if (drain) begin
      if (skd_vld_q) begin
        out_vld_d = 1'b1;
        out_imm_d = skd_imm_q;
        out_tag_d = skd_tag_q;
`ifdef MORTY_IMM_ERR_EN
        out_err_d = skd_err_q;
`endif
        skd_vld_d = accept;
        if (accept) begin
          skd_imm_d = imm_dec;
          skd_tag_d = tag_i;
`ifdef MORTY_IMM_ERR_EN
          skd_err_d = err_dec;
`endif
        end
      end else begin
        out_vld_d = accept;
        if (accept) begin
          out_imm_d = imm_dec;
          out_tag_d = tag_i;
`ifdef MORTY_IMM_ERR_EN
          out_err_d = err_dec;
`endif
        end
      end
    end else if (accept) begin
      skd_vld_d = 1'b1;
      skd_imm_d = imm_dec;
      skd_tag_d = tag_i;
`ifdef MORTY_IMM_ERR_EN
      skd_err_d = err_dec;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_imm_q <= '0;
      out_tag_q <= '0;
      skd_vld_q <= 1'b0;
      skd_imm_q <= '0;
      skd_tag_q <= '0;
`ifdef MORTY_IMM_ERR_EN
      out_err_q <= 1'b0;
      skd_err_q <= 1'b0;
`endif
    end else begin
      out_vld_q <= out_vld_d;
      out_imm_q <= out_imm_d;
      out_tag_q <= out_tag_d;
      skd_vld_q <= skd_vld_d;
      skd_imm_q <= skd_imm_d;
      skd_tag_q <= skd_tag_d;
`ifdef MORTY_IMM_ERR_EN
      out_err_q <= out_err_d;
      skd_err_q <= skd_err_d;
`endif
    end
  end

  assign valid_o = out_vld_q;
  assign imm_o   = out_imm_q;
  assign tag_o   = out_tag_q;
`ifdef MORTY_IMM_ERR_EN
  assign err_o   = out_err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_morty_imm_gen_pipe.sv
// Scoreboard bench for morty_imm_gen_pipe (XLEN=64): directed decode vectors, backpressure, flush, reset.
`timescale 1ns/1ps
module tb_morty_imm_gen_pipe;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
`ifdef MORTY_IMM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk, rst_i, flush_i, valid_i, ready_o, valid_o, ready_i, err_o;
  logic [31:0]      instruction;
  logic [2:0]       imm_sel_i;
  logic [TAG_W-1:0] tag_i, tag_o, tag_ctr;
  logic [XLEN-1:0]  imm_o;

  morty_imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction(instruction), .imm_sel_i(imm_sel_i), .tag_i(tag_i), .valid_o(valid_o),
    .ready_i(ready_i), .imm_o(imm_o), .tag_o(tag_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sbq[$];
  exp_t exp_nxt;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on negedge; the monitor samples 1ns later, so what it sees is what the next posedge sees.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: got imm 0x%0h tag %0d, expected no output", imm_o, tag_o);
        end else begin
          e = sbq.pop_front();
          chk("out_imm", 64'(imm_o), 64'(e.imm));
          chk("out_tag", 64'(tag_o), 64'(e.tag));
          chk("out_err", 64'(err_o), 64'(e.err));
        end
      end
      if (rst_i || flush_i) sbq.delete();
      else if (valid_i && ready_o) sbq.push_back(exp_nxt);
    end
  endtask

  // Called right after a negedge; returns at the negedge following acceptance with valid_i still high.
  task automatic send(input logic [2:0] sel, input logic [31:0] ins, input logic [XLEN-1:0] eimm);
    bit ok;
    imm_sel_i   = sel;
    instruction = ins;
    tag_i       = tag_ctr;
    valid_i     = 1'b1;
    exp_nxt     = '{imm: eimm, tag: tag_ctr, err: (ERR_EN && sel == 3'b111)};
    tag_ctr     = tag_ctr + 1'b1;
    ok          = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = (ready_o === 1'b1);
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: got ready_o=0 for 100 cycles, expected acceptance");
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    instruction = '0; imm_sel_i = '0; tag_i = '0; tag_ctr = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_imm",   64'(imm_o),   64'd0);
    chk("rst_tag",   64'(tag_o),   64'd0);
    chk("rst_err",   64'(err_o),   64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1 chk("ready_after_rst", 64'(ready_o), 64'd1);

    // T1: one-cycle latency, I-type
    @(negedge clk);
    ready_i = 1'b1;
    send(3'b000, 32'hFFF00093, XLEN'(64'hFFFF_FFFF_FFFF_FFFF));
    valid_i = 1'b0;
    #1;
    chk("t1_latency", 64'(valid_o), 64'd1);
    chk("t1_imm",     64'(imm_o),   64'hFFFF_FFFF_FFFF_FFFF);

    // Decode table, back-to-back at full throughput
    @(negedge clk);
    send(3'b001, 32'hFE112E23, XLEN'(64'hFFFF_FFFF_FFFF_FFFC));   // S: -4
    send(3'b010, 32'hFE000EE3, XLEN'(64'hFFFF_FFFF_FFFF_FFFC));   // B: -4
    send(3'b100, 32'h0080006F, XLEN'(64'h8));                     // J: +8
    send(3'b101, 32'h800002B7, XLEN'(64'hFFFF_FFFF_8000_0000));   // U: sign from bit 31
    send(3'b011, 32'h03F00013, XLEN'((XLEN == 64) ? 64'h3F : 64'h1F));
    send(3'b110, 32'h000F8073, XLEN'(64'h1F));
    send(3'b111, 32'hFFFFFFFF, XLEN'(64'h0));
    valid_i = 1'b0;
    repeat (3) @(negedge clk);

    // T3: backpressure, A in out, B in skid, C held by source
    ready_i = 1'b0;
    send(3'b000, 32'h00100093, XLEN'(64'h1));
    send(3'b000, 32'h00200093, XLEN'(64'h2));
    fork
      begin
        send(3'b000, 32'h00300093, XLEN'(64'h3));
        valid_i = 1'b0;
      end
      begin
        #1;
        chk("t3_ready_full", 64'(ready_o), 64'd0);
        chk("t3_hold0",      64'(imm_o),   64'h1);
        @(negedge clk);
        #1 chk("t3_hold1",   64'(imm_o),   64'h1);
        @(negedge clk);
        ready_i = 1'b1;
        #1 chk("t3_gap0", 64'(valid_o), 64'd1);
        @(negedge clk);
        #1 chk("t3_gap1", 64'(valid_o), 64'd1);
        @(negedge clk);
        #1 chk("t3_gap2", 64'(valid_o), 64'd1);
      end
    join
    repeat (3) @(negedge clk);

    // T4: flush with both entries full and a request on the same cycle
    ready_i = 1'b0;
    send(3'b000, 32'h00400093, XLEN'(64'h4));
    send(3'b000, 32'h00500093, XLEN'(64'h5));
    flush_i     = 1'b1;
    instruction = 32'h00600093;
    @(negedge clk);
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("t4_valid_cleared", 64'(valid_o), 64'd0);
    chk("t4_ready",         64'(ready_o), 64'd1);
    @(negedge clk);
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("t4_no_output", 64'(valid_o), 64'd0);

    // T5: reset mid-transfer
    @(negedge clk);
    ready_i = 1'b0;
    send(3'b000, 32'h00700093, XLEN'(64'h7));
    send(3'b000, 32'h00800093, XLEN'(64'h8));
    rst_i   = 1'b1;
    valid_i = 1'b0;
    #1 chk("t5_ready_in_rst", 64'(ready_o), 64'd0);
    @(negedge clk);
    #1;
    chk("t5_valid", 64'(valid_o), 64'd0);
    chk("t5_imm",   64'(imm_o),   64'd0);
    chk("t5_tag",   64'(tag_o),   64'd0);
    chk("t5_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1 chk("t5_ready_after", 64'(ready_o), 64'd1);

    // Traffic resumes after reset
    @(negedge clk);
    ready_i = 1'b1;
    send(3'b110, 32'h000F8073, XLEN'(64'h1F));
    valid_i = 1'b0;
    #1;
    chk("post_rst_valid", 64'(valid_o), 64'd1);
    chk("post_rst_imm",   64'(imm_o),   64'h1F);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d entries outstanding, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
